// File: rtl/x_vector_mem_port_pkg.sv
// Shared widths and helpers for the x-vector memory port slice.
package x_vector_mem_port_pkg;

    localparam int MC_ADDR_W = 48;
    localparam int DATA_W    = 64;
    localparam int RTNCTL_W  = 32;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/x_vector_mem_port_if.sv
// Convey memory-controller port: tagged load requests out, tagged responses back.
interface x_vector_mem_port_if
    import x_vector_mem_port_pkg::*;
#(
    parameter int RTNCTL_WIDTH = RTNCTL_W
);
    logic                    mc_req_ld;
    logic [MC_ADDR_W-1:0]    mc_req_vadr;
    logic [RTNCTL_WIDTH-1:0] mc_req_rtnctl;
    logic                    mc_req_stall;
    logic                    mc_rsp_push;
    logic [DATA_W-1:0]       mc_rsp_data;
    logic [RTNCTL_WIDTH-1:0] mc_rsp_rdctl;
    logic                    mc_rsp_stall;

    modport master (
        output mc_req_ld, mc_req_vadr, mc_req_rtnctl, mc_rsp_stall,
        input  mc_req_stall, mc_rsp_push, mc_rsp_data, mc_rsp_rdctl
    );

    modport slave (
        input  mc_req_ld, mc_req_vadr, mc_req_rtnctl, mc_rsp_stall,
        output mc_req_stall, mc_rsp_push, mc_rsp_data, mc_rsp_rdctl
    );
endinterface

// File: rtl/std_fifo.sv
// Show-ahead FIFO: data_o is the head entry whenever empty_o is low; pushes while full are dropped.
module std_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/x_vector_rob.sv
// Tag-indexed reorder buffer: accepts out-of-order MC data, releases it strictly in allocation order.
module x_vector_rob
    import x_vector_mem_port_pkg::*;
#(
    parameter int ROB_DEPTH      = 32,
    parameter int LOG2_ROB_DEPTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_i,
    output logic [LOG2_ROB_DEPTH-1:0] alloc_ptr_o,
    output logic                      full_o,
    input  logic                      wr_en_i,
    input  logic [LOG2_ROB_DEPTH-1:0] wr_tag_i,
    input  logic                      wr_hi_bad_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic                      rsp_push_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      err_o
);
    localparam logic [LOG2_ROB_DEPTH:0] FULL_CNT = (LOG2_ROB_DEPTH+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]      pending_q;
    logic [ROB_DEPTH-1:0]      valid_q;
    logic [DATA_W-1:0]         mem_q [ROB_DEPTH];
    logic [LOG2_ROB_DEPTH-1:0] alloc_ptr_q;
    logic [LOG2_ROB_DEPTH-1:0] deliver_ptr_q;
    logic [LOG2_ROB_DEPTH:0]   inflight_q;
    logic                      rsp_push_q;
    logic [DATA_W-1:0]         rsp_data_q;
    logic                      wr_ok;
    logic                      deliver;

    // Only a tag that is currently outstanding may land; anything else is a stray.
    assign wr_ok   = wr_en_i && !wr_hi_bad_i && pending_q[wr_tag_i];
    assign err_o   = wr_en_i && !wr_ok;
    assign deliver = valid_q[deliver_ptr_q];

    assign alloc_ptr_o = alloc_ptr_q;
    assign full_o      = (inflight_q == FULL_CNT);
    assign rsp_push_o  = rsp_push_q;
    assign rsp_data_o  = rsp_data_q;

    // NOTE: non-blocking assignments so every bit update in this block sees start-of-cycle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            valid_q       <= '0;
            alloc_ptr_q   <= '0;
            deliver_ptr_q <= '0;
            inflight_q    <= '0;
            rsp_push_q    <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            if (alloc_i) begin
                pending_q[alloc_ptr_q] <= 1'b1;
                alloc_ptr_q            <= alloc_ptr_q + 1'b1;
            end
            if (wr_ok) begin
                pending_q[wr_tag_i] <= 1'b0;
                valid_q[wr_tag_i]   <= 1'b1;
            end
            if (deliver) begin
                valid_q[deliver_ptr_q] <= 1'b0;
                deliver_ptr_q          <= deliver_ptr_q + 1'b1;
                rsp_data_q             <= mem_q[deliver_ptr_q];
            end
            rsp_push_q <= deliver;
            case ({alloc_i, deliver})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // NOTE: data storage is left unreset; valid_q alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_tag_i] <= wr_data_i;
    end

endmodule

// File: rtl/x_vector_mem_port.sv
// x-vector cache memory responder: queues reads, issues tagged MC loads, returns data in request order.
// Optional X_VECTOR_MEM_PORT_PERF_EN adds saturating issue/stall/ROB-full event counters.
module x_vector_mem_port
    import x_vector_mem_port_pkg::*;
#(
    parameter int REQ_DEPTH      = 64,
    parameter int ROB_DEPTH      = 32,
    parameter int LOG2_ROB_DEPTH = log2_ceil(ROB_DEPTH),
    parameter int RTNCTL_WIDTH   = RTNCTL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_mem,
    input  logic [MC_ADDR_W-1:0]   req_mem_addr,
    output logic                   rsp_mem_push,
    output logic [DATA_W-1:0]      rsp_mem_q,
    x_vector_mem_port_if.master    mc,
    output logic                   err
`ifdef X_VECTOR_MEM_PORT_PERF_EN
    ,
    output logic [31:0]            perf_req_cnt,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_rob_full_cnt
`endif
);
    logic [MC_ADDR_W-1:0]      fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      rob_full;
    logic                      rob_err;
    logic                      issue;
    logic [LOG2_ROB_DEPTH-1:0] alloc_ptr;
    logic                      rsp_hi_bad;

    logic                      mc_req_ld_q;
    logic [MC_ADDR_W-1:0]      mc_req_vadr_q;
    logic [LOG2_ROB_DEPTH-1:0] mc_req_tag_q;
    logic                      err_q;

    assign issue      = !fifo_empty && !mc.mc_req_stall && !rob_full;
    assign rsp_hi_bad = |mc.mc_rsp_rdctl[RTNCTL_WIDTH-1:LOG2_ROB_DEPTH];

    std_fifo #(
        .WIDTH (MC_ADDR_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_mem),
        .data_i  (req_mem_addr),
        .pop_i   (issue),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    x_vector_rob #(
        .ROB_DEPTH      (ROB_DEPTH),
        .LOG2_ROB_DEPTH (LOG2_ROB_DEPTH)
    ) u_rob (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (issue),
        .alloc_ptr_o (alloc_ptr),
        .full_o      (rob_full),
        .wr_en_i     (mc.mc_rsp_push),
        .wr_tag_i    (mc.mc_rsp_rdctl[LOG2_ROB_DEPTH-1:0]),
        .wr_hi_bad_i (rsp_hi_bad),
        .wr_data_i   (mc.mc_rsp_data),
        .rsp_push_o  (rsp_mem_push),
        .rsp_data_o  (rsp_mem_q),
        .err_o       (rob_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_req_ld_q   <= 1'b0;
            mc_req_vadr_q <= '0;
            mc_req_tag_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            mc_req_ld_q <= issue;
            if (issue) begin
                mc_req_vadr_q <= fifo_head;
                mc_req_tag_q  <= alloc_ptr;
            end
            err_q <= err_q | (req_mem && fifo_full) | rob_err;
        end
    end

    assign mc.mc_req_ld     = mc_req_ld_q;
    assign mc.mc_req_vadr   = mc_req_vadr_q;
    assign mc.mc_req_rtnctl = RTNCTL_WIDTH'(mc_req_tag_q);
    // A slot is reserved for every issued tag, so responses never need throttling.
    assign mc.mc_rsp_stall  = 1'b0;
    assign err              = err_q;

`ifdef X_VECTOR_MEM_PORT_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (issue && perf_req_q != '1)                       perf_req_q   <= perf_req_q + 1'b1;
            if (!fifo_empty && mc.mc_req_stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
            if (rob_full && perf_full_q != '1)                   perf_full_q  <= perf_full_q + 1'b1;
        end
    end

    assign perf_req_cnt      = perf_req_q;
    assign perf_stall_cnt    = perf_stall_q;
    assign perf_rob_full_cnt = perf_full_q;
`endif

endmodule

// File: tb/tb_x_vector_mem_port.sv
// Scoreboard bench for x_vector_mem_port: expected issue addresses and response words are queued at request time.
module tb_x_vector_mem_port;
    import x_vector_mem_port_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_mem;
    logic [MC_ADDR_W-1:0] req_mem_addr;
    logic                 rsp_mem_push;
    logic [DATA_W-1:0]    rsp_mem_q;
    logic                 err;
`ifdef X_VECTOR_MEM_PORT_PERF_EN
    logic [31:0]          perf_req_cnt;
    logic [31:0]          perf_stall_cnt;
    logic [31:0]          perf_rob_full_cnt;
`endif

    x_vector_mem_port_if mc_bus ();

    always #5 clk = ~clk;

    x_vector_mem_port dut (
        .clk               (clk),
        .rst               (rst),
        .req_mem           (req_mem),
        .req_mem_addr      (req_mem_addr),
        .rsp_mem_push      (rsp_mem_push),
        .rsp_mem_q         (rsp_mem_q),
        .mc                (mc_bus),
        .err               (err)
`ifdef X_VECTOR_MEM_PORT_PERF_EN
        ,
        .perf_req_cnt      (perf_req_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_rob_full_cnt (perf_rob_full_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [MC_ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W-1:0]    exp_rsp_q  [$];
    logic [4:0]           issued_tags [$];
    logic [MC_ADDR_W-1:0] tag_addr [32];
    logic [4:0]           exp_tag;
    logic [4:0]           last_tag;
    int                   ld_cnt;
    int                   rsp_cnt;
    int                   cyc = 0;
    int                   rsp_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] data_of(input logic [MC_ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hA5C3, a};
    endfunction

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mc_bus.mc_req_ld) begin
            ld_cnt++;
            check("issue_tag", 64'(mc_bus.mc_req_rtnctl), 64'(exp_tag));
            if (exp_addr_q.size() == 0) check("issue_extra", 64'(exp_addr_q.size()), 64'd1);
            else check("issue_addr", 64'(mc_bus.mc_req_vadr), 64'(exp_addr_q.pop_front()));
            tag_addr[mc_bus.mc_req_rtnctl[4:0]] = mc_bus.mc_req_vadr;
            issued_tags.push_back(mc_bus.mc_req_rtnctl[4:0]);
            last_tag = mc_bus.mc_req_rtnctl[4:0];
            exp_tag++;
        end
        if (rsp_mem_push) begin
            rsp_cnt++;
            rsp_cyc.push_back(cyc);
            if (exp_rsp_q.size() == 0) check("rsp_extra", 64'(exp_rsp_q.size()), 64'd1);
            else check("rsp_data", rsp_mem_q, exp_rsp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input string tag);
        rst                 = 1'b1;
        req_mem             = 1'b0;
        req_mem_addr        = '0;
        mc_bus.mc_req_stall = 1'b0;
        mc_bus.mc_rsp_push  = 1'b0;
        mc_bus.mc_rsp_data  = '0;
        mc_bus.mc_rsp_rdctl = '0;
        #1;
        check({tag, "_ld"},     64'(mc_bus.mc_req_ld),     64'd0);
        check({tag, "_vadr"},   64'(mc_bus.mc_req_vadr),   64'd0);
        check({tag, "_rtnctl"}, 64'(mc_bus.mc_req_rtnctl), 64'd0);
        check({tag, "_push"},   64'(rsp_mem_push),         64'd0);
        check({tag, "_rspq"},   rsp_mem_q,                 64'd0);
        check({tag, "_err"},    64'(err),                  64'd0);
        check({tag, "_rstall"}, 64'(mc_bus.mc_rsp_stall),  64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_rsp_q.delete();
        issued_tags.delete();
        rsp_cyc.delete();
        exp_tag = '0;
        ld_cnt  = 0;
        rsp_cnt = 0;
        rst     = 1'b0;
        tick();
    endtask

    task automatic send_req(input logic [MC_ADDR_W-1:0] addr, input bit expect_issue);
        req_mem      = 1'b1;
        req_mem_addr = addr;
        if (expect_issue) begin
            exp_addr_q.push_back(addr);
            exp_rsp_q.push_back(data_of(addr));
        end
        tick();
        req_mem = 1'b0;
    endtask

    task automatic mc_rsp(input logic [31:0] rdctl, input logic [DATA_W-1:0] data);
        mc_bus.mc_rsp_push  = 1'b1;
        mc_bus.mc_rsp_rdctl = rdctl;
        mc_bus.mc_rsp_data  = data;
        tick();
        mc_bus.mc_rsp_push  = 1'b0;
    endtask

    task automatic mc_ret(input logic [4:0] tag);
        mc_rsp({27'd0, tag}, data_of(tag_addr[tag]));
    endtask

    task automatic wait_issued(input int n, input string tag);
        for (int i = 0; i < 200 && ld_cnt < n; i++) tick();
        check(tag, 64'(ld_cnt), 64'(n));
    endtask

    // Plays the MC: answers every issued tag in issue order until all expected words arrive.
    task automatic drain(input int budget, input string tag);
        logic [4:0] t;
        for (int n = 0; n < budget && exp_rsp_q.size() != 0; n++) begin
            if (issued_tags.size() != 0) begin
                t                   = issued_tags.pop_front();
                mc_bus.mc_rsp_push  = 1'b1;
                mc_bus.mc_rsp_rdctl = {27'd0, t};
                mc_bus.mc_rsp_data  = data_of(tag_addr[t]);
            end else begin
                mc_bus.mc_rsp_push  = 1'b0;
            end
            tick();
        end
        mc_bus.mc_rsp_push = 1'b0;
        check(tag, 64'(exp_rsp_q.size()), 64'd0);
    endtask

    initial begin
        do_reset("reset");

        // In-order return: one word per cycle.
        for (int i = 0; i < 4; i++) send_req(48'h1000 + 48'(i * 8), 1'b1);
        wait_issued(4, "inord_issued");
        for (int i = 0; i < 4; i++) mc_ret(5'(i));
        ticks(5);
        check("inord_cnt", 64'(rsp_cnt), 64'd4);
        check("inord_cycles", 64'(rsp_cyc.size()), 64'd4);
        if (rsp_cyc.size() == 4) check("inord_span", 64'(rsp_cyc[3] - rsp_cyc[0]), 64'd3);
        check("inord_err", 64'(err), 64'd0);

        // Out-of-order return 3,1,0,2.
        do_reset("rst_ooo");
        for (int i = 0; i < 4; i++) send_req(48'h1000 + 48'(i * 8), 1'b1);
        wait_issued(4, "ooo_issued");
        mc_ret(5'd3);
        mc_ret(5'd1);
        ticks(4);
        check("ooo_hold", 64'(rsp_cnt), 64'd0);
        mc_ret(5'd0);
        ticks(4);
        check("ooo_ab", 64'(rsp_cnt), 64'd2);
        if (rsp_cyc.size() >= 2) check("ooo_ab_back2back", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'd1);
        mc_ret(5'd2);
        ticks(4);
        check("ooo_cd", 64'(rsp_cnt), 64'd4);
        check("ooo_err", 64'(err), 64'd0);

        // ROB full and tag wrap.
        do_reset("rst_full");
        for (int i = 0; i < 40; i++) send_req(48'h2000_0000 + 48'(i * 8), 1'b1);
        ticks(40);
        check("full_ld_cnt", 64'(ld_cnt), 64'd32);
        check("full_no_rsp", 64'(rsp_cnt), 64'd0);
`ifdef X_VECTOR_MEM_PORT_PERF_EN
        check("perf_full_nonzero", 64'(perf_rob_full_cnt != 0), 64'd1);
`endif
        mc_ret(5'd0);
        ticks(6);
        check("wrap_ld_cnt", 64'(ld_cnt), 64'd33);
        check("wrap_tag", 64'(last_tag), 64'd0);
        check("wrap_rsp", 64'(rsp_cnt), 64'd1);
`ifdef X_VECTOR_MEM_PORT_PERF_EN
        check("perf_req", 64'(perf_req_cnt), 64'd33);
`endif

        // MC stall during a 5-request burst.
        do_reset("rst_stall");
        mc_bus.mc_req_stall = 1'b1;
        for (int i = 0; i < 5; i++) send_req(48'hABC0_0000 + 48'(i * 8), 1'b1);
        ticks(10);
        check("stall_no_ld", 64'(ld_cnt), 64'd0);
`ifdef X_VECTOR_MEM_PORT_PERF_EN
        check("perf_stall_nonzero", 64'(perf_stall_cnt != 0), 64'd1);
`endif
        mc_bus.mc_req_stall = 1'b0;
        drain(100, "stall_drain");
        check("stall_ld_cnt", 64'(ld_cnt), 64'd5);

        // Request FIFO overflow: 65th request is dropped.
        do_reset("rst_ovf");
        mc_bus.mc_req_stall = 1'b1;
        for (int i = 0; i < 65; i++) send_req(48'h0300_0000 + 48'(i * 8), i < 64);
        tick();
        check("ovf_err", 64'(err), 64'd1);
        mc_bus.mc_req_stall = 1'b0;
        drain(600, "ovf_drain");
        ticks(5);
        check("ovf_ld_cnt", 64'(ld_cnt), 64'd64);
        check("ovf_addr_left", 64'(exp_addr_q.size()), 64'd0);

        // Unexpected tag with nothing pending.
        do_reset("rst_tag");
        mc_rsp(32'd5, 64'hDEAD_BEEF_0000_0005);
        ticks(4);
        check("badtag_err", 64'(err), 64'd1);
        check("badtag_no_rsp", 64'(rsp_cnt), 64'd0);

        // Nonzero upper rdctl bits on an otherwise valid tag.
        do_reset("rst_hi");
        send_req(48'h0000_4440, 1'b1);
        wait_issued(1, "hi_issued");
        mc_rsp(32'h0000_0100, data_of(tag_addr[0]));
        ticks(4);
        check("hibits_err", 64'(err), 64'd1);
        check("hibits_no_rsp", 64'(rsp_cnt), 64'd0);
        mc_ret(5'd0);
        ticks(4);
        check("hibits_then_ok", 64'(rsp_cnt), 64'd1);

        // Reset with 8 in flight, then a stale response.
        do_reset("rst_mid_pre");
        for (int i = 0; i < 8; i++) send_req(48'h0500_0000 + 48'(i * 8), 1'b1);
        wait_issued(8, "mid_issued");
        do_reset("midrst");
        mc_rsp(32'd2, 64'h5555_AAAA_0000_0002);
        ticks(4);
        check("stale_err", 64'(err), 64'd1);
        check("stale_no_rsp", 64'(rsp_cnt), 64'd0);
        check("stale_no_ld", 64'(ld_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
